pipe_stage_skid: RTL and testbench

- Parametrised inter-stage pipeline register, the successor to the fixed-field MEM/WB latch.
- Carries an opaque data bundle and a control bundle between two pipeline stages.
- Adds a valid/ready handshake with a two-entry skid buffer, so backpressure never loses a beat.
- Adds a whole-stage flush, a masked control-squash (generalised CP0 bubble), occupancy output and a saturating stall counter.
- Instantiated between any two stages: IF/ID, ID/EX, EX/MEM, MEM/WR.

---
 rtl/pipe_stage_skid.sv | 161 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Parametrised inter-stage pipeline register with a valid/ready handshake and a
// two-entry buffer (output register + one skid entry). Backpressure never drops
// a beat, and in_ready is registered so it has no combinational path from
// out_ready. Also provides a whole-stage flush, a masked control squash, an
// occupancy count and a saturating stall counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (registered, == !skid_valid)
//   in_data    upstream data bundle   [DATA_W]
//   in_ctrl    upstream control bundle [CTRL_W]
//   out_valid  output register holds a beat
//   out_ready  downstream accepts
//   out_data   registered data bundle [DATA_W]
//   out_ctrl   registered control bundle [CTRL_W]
//   flush      discard every held beat and the incoming beat at the next edge
//   squash     clear CTRL_KILL_MASK bits of every entry valid after the edge
//   occupancy  number of held beats (0..2)
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int                DATA_W         = 32,
  parameter int                CTRL_W         = 8,
  parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = CTRL_W'(8'h07),
  parameter int                CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              squash,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Architectural state
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Next-state values (before flush, which overrides everything)
  logic              w_out_valid_next;
  logic [DATA_W-1:0] w_out_data_next;
  logic [CTRL_W-1:0] w_out_ctrl_next;
  logic              w_skid_valid_next;
  logic [DATA_W-1:0] w_skid_data_next;
  logic [CTRL_W-1:0] w_skid_ctrl_next;

  logic w_accept;
  logic w_out_free;
  logic w_stall;

  assign w_accept   = in_valid && r_in_ready;
  // Output register can take a new beat if it is empty or being popped.
  assign w_out_free = !r_out_valid || out_ready;
  assign w_stall    = r_out_valid && !out_ready;

  always_comb begin
    w_out_valid_next  = r_out_valid;
    w_out_data_next   = r_out_data;
    w_out_ctrl_next   = r_out_ctrl;
    w_skid_valid_next = r_skid_valid;
    w_skid_data_next  = r_skid_data;
    w_skid_ctrl_next  = r_skid_ctrl;

    if (w_out_free) begin
      if (r_skid_valid) begin
        // Older skid beat drains first; in_ready is low so no accept here.
        w_out_valid_next  = 1'b1;
        w_out_data_next   = r_skid_data;
        w_out_ctrl_next   = r_skid_ctrl;
        w_skid_valid_next = 1'b0;
      end else if (w_accept) begin
        w_out_valid_next = 1'b1;
        w_out_data_next  = in_data;
        w_out_ctrl_next  = in_ctrl;
      end else begin
        w_out_valid_next = 1'b0;
      end
    end else if (w_accept) begin
      // Output stalled: park the incoming beat in the skid entry.
      w_skid_valid_next = 1'b1;
      w_skid_data_next  = in_data;
      w_skid_ctrl_next  = in_ctrl;
    end

    // Squash acts on whatever is valid after this edge, including a beat that
    // was just written or moved; data bits are untouched.
    if (squash) begin
      if (w_out_valid_next) begin
        w_out_ctrl_next = w_out_ctrl_next & ~CTRL_KILL_MASK;
      end
      if (w_skid_valid_next) begin
        w_skid_ctrl_next = w_skid_ctrl_next & ~CTRL_KILL_MASK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ctrl   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ctrl   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_out_valid  <= w_out_valid_next;
      r_out_data   <= w_out_data_next;
      r_out_ctrl   <= w_out_ctrl_next;
      r_skid_valid <= w_skid_valid_next;
      r_skid_data  <= w_skid_data_next;
      r_skid_ctrl  <= w_skid_ctrl_next;
      // Ready reflects the skid state after this edge, never out_ready directly.
      r_in_ready   <= !w_skid_valid_next;
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign occupancy = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Self-checking bench for pipe_stage_skid: a directed vector table for
// streaming, skid, flush and squash corners; a random handshake phase checked
// against a FIFO scoreboard; a long stall for counter saturation; and an
// asynchronous reset applied mid-stall.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;
  localparam logic [CTRL_W-1:0] KILL = 8'h07;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic              squash;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_skid #(
    .DATA_W        (DATA_W),
    .CTRL_W        (CTRL_W),
    .CTRL_KILL_MASK(KILL),
    .CNT_W         (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .flush    (flush),
    .squash   (squash),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] id;
    logic [CTRL_W-1:0] ic;
    logic              ordy;
    logic              fl;
    logic              sq;
    logic              ov;
    logic [DATA_W-1:0] od;
    logic [CTRL_W-1:0] oc;
    logic [1:0]        occ;
    logic              irdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [DATA_W-1:0] id, input logic [CTRL_W-1:0] ic,
                     input logic ordy, input logic fl, input logic sq,
                     input logic ov, input logic [DATA_W-1:0] od, input logic [CTRL_W-1:0] oc,
                     input logic [1:0] occ, input logic irdy);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl; v.sq = sq;
    v.ov = ov; v.od = od; v.oc = oc; v.occ = occ; v.irdy = irdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] id, input logic [CTRL_W-1:0] ic,
                       input logic ordy, input logic fl, input logic sq);
    in_valid  = iv;
    in_data   = id;
    in_ctrl   = ic;
    out_ready = ordy;
    flush     = fl;
    squash    = sq;
  endtask

  logic [DATA_W+CTRL_W-1:0] sb[$];
  logic [DATA_W+CTRL_W-1:0] front;
  int  exp_stall;
  logic prev_ov;
  logic acc, pop;

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    //   iv  data    ctrl   ordy fl sq |  ov  data    ctrl   occ rdy
    // streaming 1..4 with out_ready high
    add(1, 32'd1,  8'h10, 1, 0, 0,   1, 32'd1,  8'h10, 1, 1);
    add(1, 32'd2,  8'h20, 1, 0, 0,   1, 32'd2,  8'h20, 1, 1);
    add(1, 32'd3,  8'h30, 1, 0, 0,   1, 32'd3,  8'h30, 1, 1);
    add(1, 32'd4,  8'h40, 1, 0, 0,   1, 32'd4,  8'h40, 1, 1);
    add(0, 32'd0,  8'h00, 1, 0, 0,   0, 32'd0,  8'h00, 0, 1);
    // skid capture under backpressure, then drain in order
    add(1, 32'hA,  8'h11, 0, 0, 0,   1, 32'hA,  8'h11, 1, 1);
    add(1, 32'hB,  8'h22, 0, 0, 0,   1, 32'hA,  8'h11, 2, 0);
    add(1, 32'hC,  8'h33, 0, 0, 0,   1, 32'hA,  8'h11, 2, 0);
    add(0, 32'd0,  8'h00, 1, 0, 0,   1, 32'hB,  8'h22, 1, 1);
    add(0, 32'd0,  8'h00, 1, 0, 0,   0, 32'd0,  8'h00, 0, 1);
    // flush with full stage and an incoming beat
    add(1, 32'hA,  8'h11, 0, 0, 0,   1, 32'hA,  8'h11, 1, 1);
    add(1, 32'hB,  8'h22, 0, 0, 0,   1, 32'hA,  8'h11, 2, 0);
    add(1, 32'hC,  8'h33, 0, 1, 0,   0, 32'd0,  8'h00, 0, 1);
    add(0, 32'd0,  8'h00, 1, 0, 0,   0, 32'd0,  8'h00, 0, 1);
    // squash on accept into empty stage, then flush+squash
    add(1, 32'd5,  8'hFF, 0, 0, 1,   1, 32'd5,  8'hF8, 1, 1);
    add(0, 32'd0,  8'h00, 1, 1, 1,   0, 32'd0,  8'h00, 0, 1);
    // squash hits both the held output and the new skid entry
    add(1, 32'd6,  8'hFF, 0, 0, 0,   1, 32'd6,  8'hFF, 1, 1);
    add(1, 32'd7,  8'h0F, 0, 0, 1,   1, 32'd6,  8'hF8, 2, 0);
    add(0, 32'd0,  8'h00, 1, 0, 0,   1, 32'd7,  8'h08, 1, 1);
    add(0, 32'd0,  8'h00, 1, 0, 0,   0, 32'd0,  8'h00, 0, 1);
    // squash on an empty stage does nothing
    add(0, 32'd0,  8'h00, 1, 0, 1,   0, 32'd0,  8'h00, 0, 1);
    // simultaneous pop and accept: one beat per cycle
    add(1, 32'd8,  8'h80, 1, 0, 0,   1, 32'd8,  8'h80, 1, 1);
    add(1, 32'd9,  8'h90, 1, 0, 0,   1, 32'd9,  8'h90, 1, 1);
    add(0, 32'd0,  8'h00, 1, 0, 0,   0, 32'd0,  8'h00, 0, 1);

    exp_stall = 0;
    prev_ov   = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy, vecs[i].fl, vecs[i].sq);
      @(posedge clk);
      if (prev_ov && !vecs[i].ordy) exp_stall++;
      #1;
      $display("vec %0d: out_valid=%0b out_data=%0h out_ctrl=%0h occ=%0d in_ready=%0b",
               i, out_valid, out_data, out_ctrl, occupancy, in_ready);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
      chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].irdy));
      if (vecs[i].ov || vecs[i].fl) begin
        chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].od));
        chk($sformatf("vec%0d_out_ctrl", i), 64'(out_ctrl), 64'(vecs[i].oc));
      end
      prev_ov = vecs[i].ov;
    end
    chk("table_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    // Random handshake phase against a FIFO scoreboard.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0, 1'b0);
      pop = (sb.size() > 0) && out_ready;
      acc = in_valid && (sb.size() < 2);
      if (sb.size() > 0 && !out_ready) exp_stall++;
      @(posedge clk);
      if (pop) void'(sb.pop_front());
      if (acc) sb.push_back({in_data, in_ctrl});
      #1;
      chk($sformatf("rnd%0d_occupancy", c), 64'(occupancy), 64'(sb.size()));
      chk($sformatf("rnd%0d_in_ready", c),  64'(in_ready),  64'(sb.size() < 2));
      chk($sformatf("rnd%0d_out_valid", c), 64'(out_valid), 64'(sb.size() > 0));
      if (sb.size() > 0) begin
        front = sb[0];
        chk($sformatf("rnd%0d_out_beat", c), 64'({out_data, out_ctrl}), 64'(front));
        if (pop || acc)
          $display("rnd %0d: head data=%0h ctrl=%0h occ=%0d", c, out_data, out_ctrl, occupancy);
      end
    end
    chk("rnd_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    // Drain with a bounded cycle budget.
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4 && out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_occupancy", 64'(occupancy), 64'd0);

    // Long stall: counter must saturate and not wrap.
    drive(1'b1, 32'hDEAD, 8'h5A, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    $display("stall: stall_cnt=%0h out_valid=%0b", stall_cnt, out_valid);
    chk("stall_saturate", 64'(stall_cnt), 64'hFFFF);
    chk("stall_out_data", 64'(out_data), 64'hDEAD);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_wrap", 64'(stall_cnt), 64'hFFFF);

    // Asynchronous reset mid-cycle: outputs clear without waiting for an edge.
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: out_valid=%0b stall_cnt=%0h in_ready=%0b", out_valid, stall_cnt, in_ready);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
